timer_bank: RTL and testbench

Multi-channel programmable interval timer. It is the parametrised successor of the single-threshold counter: NCH independent channels, each with a runtime-loadable period and a one-shot or periodic mode. Each channel drives a registered expiry pulse and a sticky status flag. It sits beside the CPU core as the timebase for delays, watchdog-style timeouts and periodic events, and counts qualified ticks from a shared enable strobe.

---
 rtl/timer_bank.sv | 101 ++++++++++
 tb/tb_timer_bank.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// Multi-channel programmable interval timer: NCH channels, one-shot or periodic, shared tick.
// Optional shared tick prescaler is compiled in with `define TIMER_BANK_PRESCALE_EN.
module timer_bank #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PRESCALE = 1,
  localparam int unsigned CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_tick,
  input  logic                 i_wr,
  input  logic [CHW-1:0]       i_wr_ch,
  input  logic [WIDTH-1:0]     i_wr_period,
  input  logic                 i_wr_mode,
  input  logic [NCH-1:0]       i_stop,
  input  logic [NCH-1:0]       i_clr,
  output logic [NCH-1:0]       o_pulse,
  output logic [NCH-1:0]       o_flag,
  output logic [NCH-1:0]       o_active,
  output logic [NCH*WIDTH-1:0] o_count
);

  logic w_qtick;

`ifdef TIMER_BANK_PRESCALE_EN
  localparam int unsigned PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0] PsLast = PSW'(PRESCALE - 1);

  logic [PSW-1:0] r_div;

  // Free-running across loads and stops; only reset realigns the tick phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div <= '0;
    end else if (i_tick) begin
      r_div <= (r_div == PsLast) ? '0 : r_div + 1'b1;
    end
  end

  assign w_qtick = i_tick && (r_div == PsLast);
`else
  // PRESCALE is always >= 1, so this reduces to i_tick with no divider.
  assign w_qtick = i_tick && (PRESCALE != 0);
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_period;
    logic             r_mode;
    logic             r_active;
    logic             r_flag;
    logic             r_pulse;
    logic             w_load;

    assign w_load = i_wr && (32'(i_wr_ch) == 32'(k));

    // Priority: load > stop > advance; an expiry flag set overrides a same-cycle clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_count  <= '0;
        r_period <= '0;
        r_mode   <= 1'b0;
        r_active <= 1'b0;
        r_flag   <= 1'b0;
        r_pulse  <= 1'b0;
      end else begin
        r_pulse <= 1'b0;
        if (i_clr[k]) begin
          r_flag <= 1'b0;
        end
        if (w_load) begin
          r_count  <= '0;
          r_period <= i_wr_period;
          r_mode   <= i_wr_mode;
          r_active <= 1'b1;
        end else if (i_stop[k]) begin
          r_count  <= '0;
          r_active <= 1'b0;
        end else if (r_active && w_qtick) begin
          if (r_count < r_period) begin
            r_count <= r_count + 1'b1;
          end else begin
            r_count <= '0;
            r_pulse <= 1'b1;
            r_flag  <= 1'b1;
            if (!r_mode) begin
              r_active <= 1'b0;
            end
          end
        end
      end
    end

    assign o_pulse[k]                 = r_pulse;
    assign o_flag[k]                  = r_flag;
    assign o_active[k]                = r_active;
    assign o_count[k*WIDTH +: WIDTH]  = r_count;
  end

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: expectations are queued per clock edge and checked at negedge.
module tb_timer_bank;
  localparam int unsigned NCH      = 4;
  localparam int unsigned WIDTH    = 16;
  localparam int unsigned PRESCALE = 4;
  localparam int unsigned CHW      = 2;
`ifdef TIMER_BANK_PRESCALE_EN
  localparam int PS  = PRESCALE;
  localparam int GAP = 8;
`else
  localparam int PS  = 1;
  localparam int GAP = 2;
`endif

  logic                 clk = 1'b0;
  logic                 i_rst_n = 1'b0;
  logic                 i_tick = 1'b0;
  logic                 i_wr = 1'b0;
  logic [CHW-1:0]       i_wr_ch = '0;
  logic [WIDTH-1:0]     i_wr_period = '0;
  logic                 i_wr_mode = 1'b0;
  logic [NCH-1:0]       i_stop = '0;
  logic [NCH-1:0]       i_clr = '0;
  logic [NCH-1:0]       o_pulse;
  logic [NCH-1:0]       o_flag;
  logic [NCH-1:0]       o_active;
  logic [NCH*WIDTH-1:0] o_count;

  timer_bank #(.NCH(NCH), .WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_tick(i_tick), .i_wr(i_wr), .i_wr_ch(i_wr_ch),
    .i_wr_period(i_wr_period), .i_wr_mode(i_wr_mode), .i_stop(i_stop), .i_clr(i_clr),
    .o_pulse(o_pulse), .o_flag(o_flag), .o_active(o_active), .o_count(o_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               e;
    int               ch;
    logic             pulse;
    logic             flag;
    logic             active;
    logic [WIDTH-1:0] count;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   t0 = 0;

  // Edge e carries a qualified tick when the tick run started at t0 reaches a PS boundary.
  function automatic bit qual(input int e);
    return (e >= t0) && (((e - t0) % PS) == PS - 1);
  endfunction

  function automatic int qcount(input int l, input int e);
    int n = 0;
    for (int i = l + 1; i <= e; i++) if (qual(i)) n++;
    return n;
  endfunction

  function automatic int nth_q(input int l, input int n);
    int e = l;
    int c = 0;
    while (c < n) begin
      e++;
      if (qual(e)) c++;
    end
    return e;
  endfunction

  task automatic push(input int e, input int ch, input logic p, input logic f, input logic a,
                      input int c);
    exp_t x;
    x.e = e; x.ch = ch; x.pulse = p; x.flag = f; x.active = a; x.count = WIDTH'(c);
    sb.push_back(x);
  endtask

  // Expected outputs of an undisturbed run after a load sampled at edge l.
  task automatic push_win(input int ch, input int l, input int p, input bit m, input int e0,
                          input int e1, input logic f0);
    for (int e = e0; e <= e1; e++) begin
      int n;
      int k;
      n = qcount(l, e);
      k = n / (p + 1);
      if (!m && k >= 1) push(e, ch, e == nth_q(l, p + 1), 1'b1, 1'b0, 0);
      else push(e, ch, (k >= 1) && qual(e) && (n % (p + 1) == 0), f0 | (k >= 1), 1'b1,
                n % (p + 1));
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t x;
    while (sb.size() > 0 && sb[0].e <= cyc) begin
      x = sb.pop_front();
      n_checks++;
      if (x.e != cyc) begin
        n_err++;
        $display("FAIL stale_entry: expectation for edge %0d seen at edge %0d", x.e, cyc);
      end else begin
        if (o_pulse[x.ch] !== x.pulse) begin
          n_err++;
          $display("FAIL pulse ch%0d edge %0d: got %b want %b", x.ch, cyc, o_pulse[x.ch], x.pulse);
        end
        n_checks++;
        if (o_flag[x.ch] !== x.flag) begin
          n_err++;
          $display("FAIL flag ch%0d edge %0d: got %b want %b", x.ch, cyc, o_flag[x.ch], x.flag);
        end
        n_checks++;
        if (o_active[x.ch] !== x.active) begin
          n_err++;
          $display("FAIL active ch%0d edge %0d: got %b want %b", x.ch, cyc, o_active[x.ch],
                   x.active);
        end
        n_checks++;
        if (o_count[x.ch*WIDTH +: WIDTH] !== x.count) begin
          n_err++;
          $display("FAIL count ch%0d edge %0d: got %0d want %0d", x.ch, cyc,
                   o_count[x.ch*WIDTH +: WIDTH], x.count);
        end
      end
    end
  end

  task automatic wait_edge(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain;
    for (int i = 0; i < 200 && sb.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    i_rst_n = 1'b0; i_tick = 1'b0; i_wr = 1'b0; i_stop = '0; i_clr = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 i_rst_n = 1'b1;
    @(posedge clk);
    #1 i_tick = 1'b1;
    t0 = cyc + 1;
  endtask

  task automatic load(input int ch, input int p, input logic m, output int l);
    i_wr = 1'b1; i_wr_ch = ch[CHW-1:0]; i_wr_period = p[WIDTH-1:0]; i_wr_mode = m;
    l = cyc + 1;
    @(posedge clk);
    #1 i_wr = 1'b0;
  endtask

  task automatic test_reset;
    int l0;
    int l1;
    do_reset;
    n_checks++;
    if (o_pulse !== '0 || o_flag !== '0 || o_active !== '0 || o_count !== '0) begin
      n_err++;
      $display("FAIL reset_idle: pulse=%b flag=%b active=%b count=%h want all 0",
               o_pulse, o_flag, o_active, o_count);
    end
    load(0, 100, 1'b1, l0);
    load(1, 0, 1'b1, l1);
    wait_edge(l1 + 12);
    n_checks++;
    if (o_count[WIDTH-1:0] !== WIDTH'(qcount(l0, cyc))) begin
      n_err++;
      $display("FAIL reset_precount: got %0d want %0d", o_count[WIDTH-1:0], qcount(l0, cyc));
    end
    n_checks++;
    if (o_flag[1] !== 1'b1) begin
      n_err++;
      $display("FAIL reset_preflag: got %b want 1", o_flag[1]);
    end
    #2 i_rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_pulse !== '0 || o_flag !== '0 || o_active !== '0 || o_count !== '0) begin
      n_err++;
      $display("FAIL reset_async: pulse=%b flag=%b active=%b count=%h want all 0",
               o_pulse, o_flag, o_active, o_count);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (o_pulse !== '0 || o_flag !== '0 || o_active !== '0 || o_count !== '0) begin
      n_err++;
      $display("FAIL reset_held: pulse=%b flag=%b active=%b count=%h want all 0",
               o_pulse, o_flag, o_active, o_count);
    end
    i_rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (o_pulse !== '0 || o_flag !== '0 || o_active !== '0 || o_count !== '0) begin
      n_err++;
      $display("FAIL reset_release: pulse=%b flag=%b active=%b count=%h want all 0",
               o_pulse, o_flag, o_active, o_count);
    end
  endtask

  task automatic test_one_shot;
    int l;
    int x;
    int np = 0;
    do_reset;
    load(0, 3, 1'b0, l);
    x = nth_q(l, 4);
    push_win(0, l, 3, 1'b0, l + 1, x + 3, 1'b0);
    while (cyc < x + 3) begin
      @(posedge clk);
      #1;
      if (o_pulse[0]) np++;
    end
    n_checks++;
    if (np != 1) begin
      n_err++;
      $display("FAIL oneshot_pulses: got %0d want 1", np);
    end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (o_flag[0] !== 1'b1) begin
      n_err++;
      $display("FAIL oneshot_flag_hold: got %b want 1", o_flag[0]);
    end
    i_clr = 4'b0001;
    @(posedge clk);
    #1 i_clr = '0;
    n_checks++;
    if (o_flag[0] !== 1'b0) begin
      n_err++;
      $display("FAIL oneshot_clr: got %b want 0", o_flag[0]);
    end
    drain;
    n_checks++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL oneshot_drain: got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_periodic;
    int l;
    int np = 0;
    int want;
    do_reset;
    load(2, 0, 1'b1, l);
    push_win(2, l, 0, 1'b1, l + 1, l + 8, 1'b0);
    wait_edge(l + 8);
    load(2, 4, 1'b1, l);
    push_win(2, l, 4, 1'b1, l + 1, l + 16, 1'b1);
    want = qcount(l, l + 15) / 5;
    while (cyc < l + 15) begin
      @(posedge clk);
      #1;
      if (o_pulse[2]) np++;
    end
    n_checks++;
    if (np != want) begin
      n_err++;
      $display("FAIL periodic_count15: got %0d want %0d", np, want);
    end
    drain;
    n_checks++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL periodic_drain: got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_collision;
    int l;
    int x;
    int x2;
    int lr;
    do_reset;
    load(1, 2, 1'b0, l);
    x = nth_q(l, 3);
    push_win(1, l, 2, 1'b0, l + 1, x - 1, 1'b0);
    push(x, 1, 1'b0, 1'b0, 1'b0, 0);
    push(x + 1, 1, 1'b0, 1'b0, 1'b0, 0);
    push(x + 4, 1, 1'b0, 1'b0, 1'b0, 0);
    wait_edge(x - 1);
    i_stop = 4'b0010;
    @(posedge clk);
    #1 i_stop = '0;
    drain;
    do_reset;
    load(1, 2, 1'b0, l);
    x = nth_q(l, 3);
    x2 = nth_q(x, 6);
    push_win(1, l, 2, 1'b0, l + 1, x - 1, 1'b0);
    push(x, 1, 1'b0, 1'b0, 1'b1, 0);
    push_win(1, x, 5, 1'b0, x + 1, x2 + 1, 1'b0);
    wait_edge(x - 1);
    load(1, 5, 1'b0, lr);
    drain;
    n_checks++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL collision_drain: got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_flag_race;
    int l;
    int x;
    do_reset;
    load(3, 1, 1'b0, l);
    x = nth_q(l, 2);
    push_win(3, l, 1, 1'b0, l + 1, x + 1, 1'b0);
    push(x + 2, 3, 1'b0, 1'b0, 1'b0, 0);
    wait_edge(x - 1);
    i_clr = 4'b1000;
    @(posedge clk);
    #1 i_clr = '0;
    n_checks++;
    if (o_flag[3] !== 1'b1) begin
      n_err++;
      $display("FAIL race_flag: got %b want 1", o_flag[3]);
    end
    wait_edge(x + 1);
    i_clr = 4'b1000;
    @(posedge clk);
    #1 i_clr = '0;
    n_checks++;
    if (o_flag[3] !== 1'b0) begin
      n_err++;
      $display("FAIL race_clr_alone: got %b want 0", o_flag[3]);
    end
    drain;
  endtask

  task automatic test_prescale;
    int l;
    int p1 = -1;
    int p2 = -1;
    do_reset;
    load(0, 1, 1'b1, l);
    for (int i = 0; i < 64 && p2 < 0; i++) begin
      @(posedge clk);
      #1;
      if (o_pulse[0]) begin
        if (p1 < 0) p1 = cyc;
        else p2 = cyc;
      end
    end
    n_checks++;
    if (p2 < 0) begin
      n_err++;
      $display("FAIL prescale_timeout: got p1=%0d p2=%0d want two pulses", p1, p2);
    end else begin
      n_checks++;
      if (p2 - p1 != GAP) begin
        n_err++;
        $display("FAIL prescale_gap: got %0d want %0d", p2 - p1, GAP);
      end
    end
  endtask

  initial begin
    test_reset;
    test_one_shot;
    test_periodic;
    test_collision;
    test_flag_race;
    test_prescale;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
